// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory load/store unit and its helpers.
//   F3_*      : RV32 load/store size/sign codes carried on funct3
//   state_t   : request FSM states (IDLE, WAIT, RESP)
//   f3_legal  : whether a funct3 code is legal for a load (we=0) or a store (we=1)
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane selection and extension (combinational).
//   word    : 32-bit memory word holding the addressed data
//   addr_lo : byte offset within the word (already naturally aligned for H/W)
//   funct3  : load size/sign code (B, H, W, BU, HU); anything else yields 0
//   data    : sign- or zero-extended 32-bit load result
module mem_load_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = word[{addr_lo, 3'b000} +: 8];
    half_s = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = 32'(byte_s);
      F3_BU:   data = {24'h00_0000, byte_s};
      F3_H:    data = 32'(half_s);
      F3_HU:   data = {16'h0000, half_s};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data RAM with RV32 load/store sizing, a req/ready request
// side, a one-cycle valid response and a programmable wait-state latency.
//   i_clk, i_rst_n      : clock (posedge) and synchronous active-low reset
//   i_req / o_ready     : request handshake; accept = i_req & o_ready
//   i_we, i_funct3      : store/load select and size/sign code
//   i_addr, i_wdata     : byte address and store data (LSBs for B/H)
//   o_valid             : one-cycle response pulse, LATENCY+1 cycles after accept
//   o_rdata, o_err      : extended load data (0 for stores/errors) and error flag
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses become errors
// instead of being forced to natural alignment.
module data_memory_lsu
  import data_mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    MEM_SIZE   = 4096,
  parameter int    LATENCY    = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_req,
  output logic                        o_ready,
  input  logic                        i_we,
  input  logic [2:0]                  i_funct3,
  input  logic [$clog2(MEM_SIZE)-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]       i_wdata,
  output logic                        o_valid,
  output logic [DATA_WIDTH-1:0]       o_rdata,
  output logic                        o_err
);

  localparam int         AW    = $clog2(MEM_SIZE);
  localparam int         WORDS = MEM_SIZE / 4;
  localparam logic [3:0] LAT4  = 4'(LATENCY);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_memory_lsu: DATA_WIDTH must be 32");
  end
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("data_memory_lsu: LATENCY must be 0..15");
  end
  if ((MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_size
    $error("data_memory_lsu: MEM_SIZE must be a power of 2");
  end

  // Natural alignment of the byte offset. With trapping enabled a misaligned
  // access is an error and never touches memory, so aligning it is harmless.
  function automatic logic [1:0] eff_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   eff_lo = {lo[1], 1'b0};
      2'b10:   eff_lo = 2'b00;
      default: eff_lo = lo;
    endcase
  endfunction

  function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis     = (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
    req_bad = !f3_legal(we, f3) || (TRAP_MISALIGN && mis);
  endfunction

  logic [31:0] mem [WORDS] = '{default: '0};

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             accept, req_err, wr_en;
  logic [1:0]       req_lo;
  logic [3:0]       be;
  logic [31:0]      lane_data;
  logic             rsp_fire, rsp_we, rsp_err;
  logic [2:0]       rsp_f3;
  logic [AW-1:0]    rsp_addr;
  logic [1:0]       rsp_lo;
  logic [31:0]      rd_word, ld_data;

  assign o_ready = (state != WAIT);
  assign o_valid = (state == RESP);
  assign accept  = i_req & o_ready;
  assign req_lo  = eff_lo(i_funct3, i_addr[1:0]);
  assign req_err = req_bad(i_we, i_funct3, i_addr[1:0]);
  assign wr_en   = accept & i_we & ~req_err & i_rst_n;

  always_comb begin
    be        = 4'b0000;
    lane_data = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << req_lo;
        lane_data = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be        = req_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{i_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Stage p0: stores commit on the accept edge
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[i_addr[AW-1:2]][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // With no wait states the response is built from the live request on the
  // accept edge; otherwise from the request latched at accept.
  if (LATENCY == 0) begin : g_direct
    assign rsp_fire = accept;
    assign rsp_we   = i_we;
    assign rsp_f3   = i_funct3;
    assign rsp_addr = i_addr;
  end else begin : g_latched
    logic          we_p0;
    logic [2:0]    f3_p0;
    logic [AW-1:0] addr_p0;

    always_ff @(posedge i_clk) begin
      if (accept) begin
        we_p0   <= i_we;
        f3_p0   <= i_funct3;
        addr_p0 <= i_addr;
      end
    end

    assign rsp_fire = (state == WAIT) && (cnt == 4'd1);
    assign rsp_we   = we_p0;
    assign rsp_f3   = f3_p0;
    assign rsp_addr = addr_p0;
  end

  assign rsp_err = req_bad(rsp_we, rsp_f3, rsp_addr[1:0]);
  assign rsp_lo  = eff_lo(rsp_f3, rsp_addr[1:0]);
  assign rd_word = mem[rsp_addr[AW-1:2]];

  mem_load_ext u_ext (
    .word    (rd_word),
    .addr_lo (rsp_lo),
    .funct3  (rsp_f3),
    .data    (ld_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = accept ? ((LATENCY == 0) ? RESP : WAIT) : IDLE;
      WAIT:       if (cnt == 4'd1) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  // Stage p1: response registers loaded on entry to RESP
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      o_rdata <= '0;
      o_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= LAT4;
      else if (state == WAIT)  cnt <= cnt - 4'd1;
      if (rsp_fire) begin
        o_err   <= rsp_err;
        o_rdata <= (rsp_err || rsp_we) ? '0 : ld_data;
      end
    end
  end

endmodule
